sensor_tx_scheduler: RTL
========================

Name: sensor_tx_scheduler

Overview:
Schedules the shared single-port 8-bit sample memory between the sensor capture path and the radio transmit path. Sensor samples are logged into a circular buffer in memory. Once BURST_LEN samples are buffered, the block reads them back one at a time and hands each byte to the radio using a send/busy handshake. It sits between the sensor front end, the sample memory and the radio, and replaces ad-hoc sequencing in the node controller.

Parameters:
ADDR_W, 8, memory address width; buffer depth DEPTH = 2**ADDR_W.
BURST_LEN, 8, samples per radio burst; legal range 1..DEPTH.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
enable  in  1  block enable; 0 = synchronous soft clear (see Behaviour).
sample_valid  in  1  one-cycle strobe; sample_data is valid this cycle.
sample_data  in  8  sensor sample.
mem_data_in  in  8  memory read data; valid the cycle after mem_read.
mem_data_out  out  8  memory write data.
mem_address  out  ADDR_W  memory address.
mem_write  out  1  memory write strobe.
mem_read  out  1  memory read strobe.
radio_busy  in  1  radio is transmitting a byte.
radio_send  out  1  one-cycle transmit request.
radio_tx_data  out  8  byte to transmit; stable from SEND until the next READ_WAIT.
radio_enable  out  1  high for the whole of an active burst.
fill_count  out  ADDR_W+1  samples currently buffered (0..DEPTH).
overflow  out  1  sticky flag: a sample was dropped.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. All outputs and state are registered.
- Reset values: every output is 0, FSM=IDLE, wr_ptr=rd_ptr=0, count=0, hold_valid=0, burst_active=0, burst_rem=0.
- enable=0, sampled at clk: forces every register to its reset value, including overflow. Memory contents are don't-care.
- Sample capture runs in every state. A sample_valid strobe loads the hold register and sets hold_valid.
  - If hold_valid is already 1 and is not being consumed this cycle, the new sample is dropped and overflow is set.
- FSM states: IDLE, WRITE, READ_REQ, READ_WAIT, SEND, WAIT_BUSY. Decisions are taken in IDLE in this priority order:
  1. hold_valid and count<DEPTH -> WRITE.
  2. hold_valid and count==DEPTH -> discard hold (hold_valid=0), set overflow, stay in IDLE.
  3. !burst_active and count>=BURST_LEN and !radio_busy -> burst_active=1, burst_rem=BURST_LEN, radio_enable=1, go to READ_REQ.
  4. burst_active and burst_rem>0 and !radio_busy -> READ_REQ.
  5. burst_active and burst_rem==0 -> burst_active=0, radio_enable=0.
- WRITE (1 cycle):
  - mem_write=1, mem_address=wr_ptr, mem_data_out=hold.
  - Then wr_ptr+1, count+1, hold_valid=0, go to IDLE.
- READ_REQ (1 cycle): mem_read=1, mem_address=rd_ptr, go to READ_WAIT.
- READ_WAIT (1 cycle): latch mem_data_in into radio_tx_data, go to SEND.
- SEND (1 cycle):
  - radio_send=1.
  - Then rd_ptr+1, count-1, burst_rem-1, go to WAIT_BUSY.
- WAIT_BUSY:
  - The first cycle is a grace cycle; radio_busy is ignored.
  - Afterwards, exit to IDLE on the first cycle radio_busy==0.
- Strobes (mem_write, mem_read, radio_send) are high only during their named state; they are never asserted together.
- Per-byte latency: SEND occurs 3 cycles after leaving IDLE. Minimum byte period is 5 cycles plus the radio busy time.
- Arithmetic:
  - wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH with no special case.
  - count changes by at most 1 per cycle, because write and read are serialised by the FSM.
  - fill_count = count.
- Pending samples during a burst: a sample arriving mid-burst waits in the hold register. It is written at the next IDLE visit, which is between bytes, so writes interleave with burst reads.
- Mid-operation events:
  - rst asserted anywhere returns all state to reset values immediately.
  - enable deasserted mid-burst aborts at the next clock edge. radio_send never re-asserts for the aborted byte.

Decomposition:
- Package sensor_node_pkg holds:
  - the state enum typedef (IDLE..WAIT_BUSY, 3 bits);
  - default constants for ADDR_W and BURST_LEN.
- The circular-buffer pointer/count logic (wr_ptr, rd_ptr, count, full/empty) is a natural sub-module: ring_ptr_ctrl.
  - Inputs: push, pop.
  - Outputs: wr_ptr, rd_ptr, count, full, empty.
  - The FSM, hold register and radio handshake stay in the top level.

Test Plan:
- Reset/idle: pulse rst mid-run with count=5 -> all outputs 0 within the same cycle, fill_count=0, no strobes afterwards.
- Threshold burst: 8 samples 0x10..0x17, radio_busy high 3 cycles after each send -> exactly 8 radio_send pulses carrying 0x10..0x17 in order, reads from addresses 0..7; radio_enable high from the first READ_REQ to after the 8th byte; fill_count ends at 0.
- Wrap-around: write 300 samples with the radio idle (BURST_LEN=8) -> addresses wrap 0xFF->0x00, transmitted bytes match the write order, and no overflow.
- Full buffer: radio_busy held at 1, 257 samples -> 256 writes, fill_count=256, 257th sample dropped, overflow=1, no write to address 0 over stale data.
- Hold collision: two sample_valid strobes on consecutive cycles while in WAIT_BUSY -> the second is dropped, overflow=1; the first is written at the next IDLE.
- Enable abort: enable=0 during READ_WAIT of byte 3 -> no radio_send for byte 3; all registers cleared, including overflow; after re-enable, 8 fresh samples produce a normal burst starting at address 0.

Source files
------------

// File: rtl/sensor_node_pkg.sv
// rtl/sensor_node_pkg.sv - shared types and default sizing for the sensor node scheduler
package sensor_node_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ_REQ  = 3'd2,
    S_READ_WAIT = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_BUSY = 3'd5
  } state_t;

endpackage

// File: rtl/ring_ptr_ctrl.sv
// rtl/ring_ptr_ctrl.sv - circular buffer write/read pointers and occupancy count
module ring_ptr_ctrl
  import sensor_node_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic do_push;
  logic do_pop;

  // Guards keep the count in range even if a caller strobes out of turn.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/sensor_tx_scheduler.sv
// rtl/sensor_tx_scheduler.sv - arbitrates the sample memory between sensor logging and radio bursts
module sensor_tx_scheduler
  import sensor_node_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [7:0]        sample_data,
  input  logic [7:0]        mem_data_in,
  output logic [7:0]        mem_data_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  input  logic              radio_busy,
  output logic              radio_send,
  output logic [7:0]        radio_tx_data,
  output logic              radio_enable,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] BURST_C = (ADDR_W + 1)'(BURST_LEN);

  state_t            state;
  logic [7:0]        hold_data;
  logic              hold_valid;
  logic              burst_active;
  logic [ADDR_W:0]   burst_rem;
  logic              grace;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              hold_consume;

  assign push = (state == S_WRITE);
  assign pop  = (state == S_SEND);

  // The hold register empties either by being written or by being discarded on a full buffer.
  assign hold_consume = (state == S_WRITE) || ((state == S_IDLE) && hold_valid && full);

  ring_ptr_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_ring (
    .clk   (clk),
    .rst   (rst),
    .clear (~enable),
    .push  (push),
    .pop   (pop),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign fill_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      burst_active  <= 1'b0;
      burst_rem     <= '0;
      grace         <= 1'b0;
      mem_data_out  <= '0;
      mem_address   <= '0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;
      radio_send    <= 1'b0;
      radio_tx_data <= '0;
      radio_enable  <= 1'b0;
      overflow      <= 1'b0;
    end else if (!enable) begin
      state         <= S_IDLE;
      hold_data     <= '0;
      hold_valid    <= 1'b0;
      burst_active  <= 1'b0;
      burst_rem     <= '0;
      grace         <= 1'b0;
      mem_data_out  <= '0;
      mem_address   <= '0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;
      radio_send    <= 1'b0;
      radio_tx_data <= '0;
      radio_enable  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      // Capture runs regardless of FSM state; a busy hold register drops the newcomer.
      if (sample_valid && hold_valid && !hold_consume) overflow <= 1'b1;
      if (sample_valid && (!hold_valid || hold_consume)) begin
        hold_data  <= sample_data;
        hold_valid <= 1'b1;
      end else if (hold_consume) begin
        hold_valid <= 1'b0;
      end

      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      radio_send <= 1'b0;

      case (state)
        S_IDLE: begin
          if (hold_valid && !full) begin
            state        <= S_WRITE;
            mem_write    <= 1'b1;
            mem_address  <= wr_ptr;
            mem_data_out <= hold_data;
          end else if (hold_valid) begin
            overflow <= 1'b1;
          end else if (!burst_active && (count >= BURST_C) && !radio_busy) begin
            burst_active <= 1'b1;
            burst_rem    <= BURST_C;
            radio_enable <= 1'b1;
            state        <= S_READ_REQ;
            mem_read     <= 1'b1;
            mem_address  <= rd_ptr;
          end else if (burst_active && (burst_rem != '0) && !empty && !radio_busy) begin
            state       <= S_READ_REQ;
            mem_read    <= 1'b1;
            mem_address <= rd_ptr;
          end else if (burst_active && (burst_rem == '0)) begin
            burst_active <= 1'b0;
            radio_enable <= 1'b0;
          end
        end
        S_WRITE: begin
          state <= S_IDLE;
        end
        S_READ_REQ: begin
          state <= S_READ_WAIT;
        end
        S_READ_WAIT: begin
          radio_tx_data <= mem_data_in;
          radio_send    <= 1'b1;
          state         <= S_SEND;
        end
        S_SEND: begin
          burst_rem <= burst_rem - 1'b1;
          grace     <= 1'b1;
          state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // The radio may not raise busy until a cycle after the send strobe.
          if (grace) begin
            grace <= 1'b0;
          end else if (!radio_busy) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
